// File: rtl/wb_ntp_defs.sv
// wb_ntp_defs: state encodings and address-map constants shared by the NTP master and slave
package wb_ntp_defs;
    typedef enum logic [2:0] {IDLE, LO, GAP, HI, RSP} state_t;
    localparam int NTP_IDX_W = 3;
    localparam int WB_ADR_W  = 6;
    localparam int HALF_BIT  = 2;
    function automatic logic [WB_ADR_W-1:0] wb_addr(input logic [NTP_IDX_W-1:0] idx, input logic half);
        return {idx, half, 2'b00};
    endfunction
endpackage

// File: rtl/wb_ack_timeout.sv
// wb_ack_timeout: counts strobe cycles without ack and flags the last allowed cycle
module wb_ack_timeout #(
    parameter int LIMIT = 255,
    parameter int TW    = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [TW-1:0] cnt;
    // count waiting cycles, restarting whenever the strobe is low
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt <= '0;
        else if (i_clr) cnt <= '0;
        else if (i_en) cnt <= cnt + 1'b1;
    // high in the cycle whose missing ack would make LIMIT unanswered strobe cycles
    assign o_expired = cnt == TW'(LIMIT - 1);
endmodule

// File: rtl/wb_ntp_master.sv
// wb_ntp_master: splits 64-bit register commands into two 32-bit Wishbone classic transactions
module wb_ntp_master
    import wb_ntp_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [NTP_IDX_W-1:0] i_cmd_idx,
    input  logic [63:0]         i_cmd_wdata,
    input  logic [7:0]          i_cmd_sel,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [63:0]         o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [WB_ADR_W-1:0] o_wb_adr,
    output logic [31:0]         o_wb_dat,
    output logic [3:0]          o_wb_sel,
    output logic                o_wb_we,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    input  logic                i_wb_ack,
    input  logic [31:0]         i_wb_rdt
);
    state_t state, state_n;
    logic                 rdy_q, we_q, err_q, expired, accept, hi_half;
    logic [NTP_IDX_W-1:0] idx_q;
    logic [63:0]          wdata_q, rdata_q;
    logic [7:0]           sel_q;

    wb_ack_timeout #(.LIMIT(TIMEOUT_CYCLES), .TW(TW)) u_tmo (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(!o_wb_stb),
        .i_en(o_wb_stb && !i_wb_ack), .o_expired(expired)
    );

    assign accept  = i_cmd_valid && o_cmd_ready;
    assign hi_half = state == HI;

    // next state and bus/handshake strobes; an ack always beats an expiring timeout
    always_comb begin
        state_n     = state;
        o_cmd_ready = 1'b0;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = rdy_q;
                if (i_cmd_valid && rdy_q)
                    state_n = !i_cmd_we ? LO : i_cmd_sel == 8'h00 ? RSP : i_cmd_sel[3:0] == 4'h0 ? HI : LO;
            end
            LO: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (i_wb_ack) state_n = (we_q && sel_q[7:4] == 4'h0) ? RSP : GAP;
                else if (expired) state_n = RSP;
            end
            GAP: begin
                o_wb_cyc = 1'b1;
                state_n  = HI;
            end
            HI: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (i_wb_ack || expired) state_n = RSP;
            end
            RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_wb_adr    = wb_addr(idx_q, hi_half);
    assign o_wb_dat    = o_wb_stb ? (hi_half ? wdata_q[63:32] : wdata_q[31:0]) : 32'h0;
    assign o_wb_sel    = !o_wb_stb ? 4'h0 : !we_q ? 4'hF : hi_half ? sel_q[7:4] : sel_q[3:0];
    assign o_wb_we     = o_wb_stb && we_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    // state, latched command and response capture; ready is held off until the first clock after reset
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= 1'b1;
            if (accept) begin
                we_q    <= i_cmd_we;
                idx_q   <= i_cmd_idx;
                wdata_q <= i_cmd_wdata;
                sel_q   <= i_cmd_sel;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (o_wb_stb && i_wb_ack) begin
                if (!we_q && hi_half) rdata_q[63:32] <= i_wb_rdt;
                if (!we_q && !hi_half) rdata_q[31:0] <= i_wb_rdt;
            end else if (o_wb_stb && expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
endmodule

// File: tb/tb_wb_ntp_master.sv
// tb_wb_ntp_master: randomized and directed checks of wb_ntp_master against a 64-bit register model
module tb_wb_ntp_master;
    localparam int TMO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_cmd_valid = 1'b0, i_cmd_we = 1'b0, i_rsp_ready = 1'b0;
    logic [2:0]  i_cmd_idx = '0;
    logic [63:0] i_cmd_wdata = '0;
    logic [7:0]  i_cmd_sel = '0;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_wb_we, o_wb_cyc, o_wb_stb;
    logic [63:0] o_rsp_rdata;
    logic [5:0]  o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        ack;
    logic [31:0] rdt;
    logic        ack_en = 1'b1;

    int checks = 0, errors = 0;
    int stb_n = 0, gap_n = 0;
    logic [42:0] txq[$];
    logic [63:0] ref_mem[8];
    logic [31:0] smem[16];

    always #5 clk = ~clk;

    wb_ntp_master #(.TIMEOUT_CYCLES(TMO), .TW(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_we(i_cmd_we), .i_cmd_idx(i_cmd_idx), .i_cmd_wdata(i_cmd_wdata), .i_cmd_sel(i_cmd_sel),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_ack(ack), .i_wb_rdt(rdt)
    );

    // registered-ack slave; its storage is reloaded from the reference model during reset
    always @(posedge clk or posedge rst)
        if (rst) begin
            ack <= 1'b0;
            rdt <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= i[0] ? ref_mem[i/2][63:32] : ref_mem[i/2][31:0];
        end else begin
            ack <= o_wb_cyc && o_wb_stb && !ack && ack_en;
            if (o_wb_cyc && o_wb_stb && !ack && ack_en) begin
                rdt <= smem[o_wb_adr[5:2]];
                if (o_wb_we)
                    for (int b = 0; b < 4; b++)
                        if (o_wb_sel[b]) smem[o_wb_adr[5:2]][8*b +: 8] <= o_wb_dat[8*b +: 8];
            end
        end

    // bus monitor sampled mid-cycle
    always @(negedge clk)
        if (!rst) begin
            if (o_wb_stb) stb_n++;
            if (o_wb_cyc && !o_wb_stb) gap_n++;
            if (o_wb_stb && ack) txq.push_back({o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat});
        end

    task automatic run_cmd(input bit we, input logic [2:0] idx, input logic [63:0] wd,
                           input logic [7:0] sel, input int hold, input bit exp_to);
        bit lo, hi, hold_bad;
        int exp_lat, exp_stb, exp_gap, lat, s0, g0, t0, nt;
        logic [63:0] exp_rd, got_rd;
        logic got_err;
        logic [42:0] exp_tx[$];
        lo = !we || (sel[3:0] != 0);
        hi = !we || (sel[7:4] != 0);
        exp_lat = exp_to ? TMO + 1 : (lo && hi) ? 6 : (lo || hi) ? 3 : 1;
        exp_stb = exp_to ? TMO : 2 * (int'(lo) + int'(hi));
        exp_gap = (lo && hi && !exp_to) ? 1 : 0;
        exp_rd  = (we || exp_to) ? 64'h0 : ref_mem[idx];
        if (!exp_to && lo) exp_tx.push_back({idx, 1'b0, 2'b00, we, we ? sel[3:0] : 4'hF, wd[31:0]});
        if (!exp_to && hi) exp_tx.push_back({idx, 1'b1, 2'b00, we, we ? sel[7:4] : 4'hF, wd[63:32]});
        s0 = stb_n; g0 = gap_n; t0 = txq.size();
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_idx = idx; i_cmd_wdata = wd; i_cmd_sel = sel;
        lat = 0;
        while (!o_cmd_ready && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready got %b want 1", o_cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        lat = 1;
        while (o_rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL latency got %0d want %0d", lat, exp_lat); end
        got_rd = o_rsp_rdata; got_err = o_rsp_err;
        checks++;
        if (got_rd !== exp_rd) begin errors++; $display("FAIL rdata got %h want %h", got_rd, exp_rd); end
        checks++;
        if (got_err !== exp_to) begin errors++; $display("FAIL err got %b want %b", got_err, exp_to); end
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== got_rd || o_rsp_err !== got_err || o_cmd_ready !== 1'b0 || o_wb_cyc !== 1'b0)
                hold_bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad) begin errors++; $display("FAIL hold_stable got unstable want stable"); end
        end
        i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rsp_ready = 1'b0;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0)
            begin errors++; $display("FAIL after_rsp got ready=%b valid=%b want 1 0", o_cmd_ready, o_rsp_valid); end
        checks++;
        if (stb_n - s0 !== exp_stb) begin errors++; $display("FAIL stb_cycles got %0d want %0d", stb_n - s0, exp_stb); end
        checks++;
        if (gap_n - g0 !== exp_gap) begin errors++; $display("FAIL gap_cycles got %0d want %0d", gap_n - g0, exp_gap); end
        nt = txq.size() - t0;
        checks++;
        if (nt !== exp_tx.size()) begin errors++; $display("FAIL tx_count got %0d want %0d", nt, exp_tx.size()); end
        for (int i = 0; i < nt && i < exp_tx.size(); i++) begin
            checks++;
            if (txq[t0+i] !== exp_tx[i]) begin errors++; $display("FAIL tx%0d got %h want %h", i, txq[t0+i], exp_tx[i]); end
        end
        if (we && !exp_to)
            for (int b = 0; b < 8; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb} !== '0)
            begin errors++; $display("FAIL reset_outputs got nonzero want 0"); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk got %b want 0", o_cmd_ready); end
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk got %b want 1", o_cmd_ready); end
    endtask

    task automatic test_directed();
        run_cmd(1'b0, 3'd3, 64'h0, 8'h00, 0, 1'b0);
        run_cmd(1'b1, 3'd1, 64'hDEADBEEF_CAFEF00D, 8'hF0, 0, 1'b0);
        run_cmd(1'b1, 3'd5, 64'h1111_2222_3333_4444, 8'h00, 0, 1'b0);
        run_cmd(1'b0, 3'd1, 64'h0, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        run_cmd(1'b0, 3'd2, 64'h0, 8'hFF, 0, 1'b1);
        ack_en = 1'b1;
        run_cmd(1'b0, 3'd2, 64'h0, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_cmd(1'b0, 3'd6, 64'h0, 8'h00, 10, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] sel;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0: sel = 8'h00;
                1: sel = 8'hF0;
                2: sel = 8'h0F;
                default: sel = 8'($urandom);
            endcase
            run_cmd(1'($urandom), 3'($urandom), {$urandom, $urandom}, sel, 0, 1'b0);
        end
    endtask

    task automatic test_reset_in_hi();
        int n;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_idx = 3'd4; i_cmd_sel = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        n = 0;
        while (!(o_wb_stb && o_wb_adr[2]) && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!(o_wb_stb && o_wb_adr[2])) begin errors++; $display("FAIL reach_hi got stb=%b adr=%h want HI", o_wb_stb, o_wb_adr); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_rsp_valid, o_cmd_ready} !== 4'b0)
            begin errors++; $display("FAIL async_reset got %b want 0000", {o_wb_cyc, o_wb_stb, o_rsp_valid, o_cmd_ready}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", o_cmd_ready); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_rsp_valid || o_wb_cyc) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL spurious_activity got %0d want 0", n); end
        run_cmd(1'b0, 3'd4, 64'h0, 8'hFF, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = {$urandom, $urandom};
        ref_mem[3] = 64'h01234567_89ABCDEF;
        test_reset();
        test_directed();
        test_timeout();
        test_hold();
        test_random();
        test_reset_in_hi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
